// File: rtl/dsram_arbiter_if.sv
// Bus bundle between the two requesters, the data SRAM and dsram_arbiter.
`default_nettype none

interface dsram_arbiter_if;
  logic        p_req;
  logic        p_wr;
  logic [3:0]  p_wstrb;
  logic [31:0] p_addr;
  logic [31:0] p_wdata;
  logic        p_addr_ok;
  logic        p_data_ok;
  logic [31:0] p_rdata;

  logic        a_req;
  logic        a_wr;
  logic [3:0]  a_wstrb;
  logic [31:0] a_addr;
  logic [31:0] a_wdata;
  logic        a_addr_ok;
  logic        a_data_ok;
  logic [31:0] a_rdata;

  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  modport slave (
    input  p_req, p_wr, p_wstrb, p_addr, p_wdata,
    output p_addr_ok, p_data_ok, p_rdata,
    input  a_req, a_wr, a_wstrb, a_addr, a_wdata,
    output a_addr_ok, a_data_ok, a_rdata,
    output sram_en, sram_we, sram_addr, sram_wdata,
    input  sram_rdata
  );

  modport master (
    output p_req, p_wr, p_wstrb, p_addr, p_wdata,
    input  p_addr_ok, p_data_ok, p_rdata,
    output a_req, a_wr, a_wstrb, a_addr, a_wdata,
    input  a_addr_ok, a_data_ok, a_rdata,
    input  sram_en, sram_we, sram_addr, sram_wdata,
    output sram_rdata
  );
endinterface

`default_nettype wire

// File: rtl/dsram_arbiter.sv
// +--------------------------------------------------------------------+
// | dsram_arbiter: pipeline/aux arbiter for the single-port data SRAM,  |
// | one outstanding access, fixed read latency, aux starvation guard.   |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module dsram_arbiter #(
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic           clk,
  input  logic           resetn,
  dsram_arbiter_if.slave bus
);

  localparam logic [2:0] c_LAT_INIT   = 3'(RD_LAT);
  localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_MAX);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_P = 2'd1, OWN_A = 2'd2} owner_t;

  state_t     r_state;
  owner_t     r_owner;
  logic [2:0] r_lat_cnt;
  logic [3:0] r_starve_cnt;

  logic w_last;
  logic w_can_accept;
  logic w_a_win;
  logic w_p_win;

  // resetn gating keeps every output quiet while reset is held, even with requests up
  assign w_last       = resetn && (r_state == ST_WAIT) && (r_lat_cnt == 3'd1);
  assign w_can_accept = resetn && ((r_state == ST_IDLE) || w_last);
  assign w_a_win      = w_can_accept && bus.a_req &&
                        (!bus.p_req || (r_starve_cnt == c_STARVE_MAX));
  assign w_p_win      = w_can_accept && bus.p_req && !w_a_win;

  assign bus.p_addr_ok = w_p_win;
  assign bus.a_addr_ok = w_a_win;
  assign bus.p_data_ok = w_last && (r_owner == OWN_P);
  assign bus.a_data_ok = w_last && (r_owner == OWN_A);
  assign bus.p_rdata   = bus.p_data_ok ? bus.sram_rdata : 32'd0;
  assign bus.a_rdata   = bus.a_data_ok ? bus.sram_rdata : 32'd0;

  always_comb begin
    bus.sram_en    = w_a_win | w_p_win;
    bus.sram_we    = 4'b0000;
    bus.sram_addr  = 32'd0;
    bus.sram_wdata = 32'd0;
    if (w_a_win) begin
      bus.sram_we    = bus.a_wr ? bus.a_wstrb : 4'b0000;
      bus.sram_addr  = bus.a_addr;
      bus.sram_wdata = bus.a_wdata;
    end else if (w_p_win) begin
      bus.sram_we    = bus.p_wr ? bus.p_wstrb : 4'b0000;
      bus.sram_addr  = bus.p_addr;
      bus.sram_wdata = bus.p_wdata;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= ST_IDLE;
      r_owner      <= OWN_NONE;
      r_lat_cnt    <= 3'd0;
      r_starve_cnt <= 4'd0;
    end else begin
      // a grant in the final WAIT cycle overlaps the completion of the previous access
      if (w_a_win || w_p_win) begin
        r_state   <= ST_WAIT;
        r_lat_cnt <= c_LAT_INIT;
        r_owner   <= w_a_win ? OWN_A : OWN_P;
      end else if (r_state == ST_WAIT) begin
        if (r_lat_cnt == 3'd1) begin
          r_state   <= ST_IDLE;
          r_owner   <= OWN_NONE;
          r_lat_cnt <= 3'd0;
        end else begin
          r_lat_cnt <= r_lat_cnt - 3'd1;
        end
      end

      if (w_p_win) begin
        if (!bus.a_req) begin
          r_starve_cnt <= 4'd0;
        end else if (r_starve_cnt != c_STARVE_MAX) begin
          r_starve_cnt <= r_starve_cnt + 4'd1;
        end
      end else if (w_a_win) begin
        r_starve_cnt <= 4'd0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dsram_arbiter.sv
// Randomized bench for dsram_arbiter against a cycle-count based reference model.
`default_nettype none

module tb_dsram_arbiter;

  localparam int RD_LAT     = 2;
  localparam int STARVE_MAX = 4;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  dsram_arbiter_if bus ();

  dsram_arbiter #(.RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)) u_dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: the access granted in cycle g completes in cycle g+RD_LAT,
  // and the SRAM is free for a new grant in any cycle at or after that one.
  int cyc      = 0;
  int busy_end = -1;
  int m_owner  = 0;
  int starve   = 0;

  // requester state, index 0 = pipeline, 1 = aux
  bit          req   [2];
  bit          wr    [2];
  logic [3:0]  strb  [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  bit          outst [2];
  int          rate  [2];

  bit record_en = 1'b0;
  int gq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic drive_bus();
    bus.p_req   = req[0];   bus.a_req   = req[1];
    bus.p_wr    = wr[0];    bus.a_wr    = wr[1];
    bus.p_wstrb = strb[0];  bus.a_wstrb = strb[1];
    bus.p_addr  = addr[0];  bus.a_addr  = addr[1];
    bus.p_wdata = wdata[0]; bus.a_wdata = wdata[1];
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_p_addr_ok"}, 32'(bus.p_addr_ok), 0);
    chk({pfx, "_a_addr_ok"}, 32'(bus.a_addr_ok), 0);
    chk({pfx, "_p_data_ok"}, 32'(bus.p_data_ok), 0);
    chk({pfx, "_a_data_ok"}, 32'(bus.a_data_ok), 0);
    chk({pfx, "_sram_en"},   32'(bus.sram_en), 0);
    chk({pfx, "_sram_we"},   32'(bus.sram_we), 0);
    chk({pfx, "_sram_addr"}, bus.sram_addr, 0);
    chk({pfx, "_sram_wdata"}, bus.sram_wdata, 0);
    chk({pfx, "_p_rdata"},   bus.p_rdata, 0);
    chk({pfx, "_a_rdata"},   bus.a_rdata, 0);
  endtask

  // Entered at posedge+1 (or time 0); returns at posedge+1 with the DUT out of reset.
  task automatic apply_reset(input int ncyc);
    for (int k = 0; k < 2; k++) begin
      req[k] = 1'b1; wr[k] = 1'b1; strb[k] = 4'hF;
      addr[k] = $urandom; wdata[k] = $urandom;
    end
    drive_bus();
    bus.sram_rdata = $urandom;
    resetn = 1'b0;
    #1;
    chk_all_zero("rst");
    for (int k = 0; k < 2; k++) begin
      req[k] = 1'b0; outst[k] = 1'b0;
    end
    drive_bus();
    repeat (ncyc) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    resetn   = 1'b1;
    busy_end = -1;
    starve   = 0;
  endtask

  task automatic do_cycle();
    bit          done, can, win_a, win_p, win;
    int          w;
    logic [31:0] rd;
    done = (busy_end == cyc);
    can  = (busy_end <= cyc);
    for (int k = 0; k < 2; k++) begin
      if (outst[k] && done && m_owner == k) outst[k] = 1'b0;
      if (!req[k] && !outst[k] && (int'($urandom_range(99)) < rate[k])) begin
        req[k]   = 1'b1;
        wr[k]    = 1'($urandom_range(1));
        strb[k]  = 4'($urandom_range(15));
        addr[k]  = $urandom;
        wdata[k] = $urandom;
      end
    end
    drive_bus();
    rd = $urandom;
    bus.sram_rdata = rd;

    win_a = can && req[1] && (!req[0] || starve >= STARVE_MAX);
    win_p = can && req[0] && !win_a;
    win   = win_a || win_p;
    w     = win_a ? 1 : 0;

    #3;
    chk("p_addr_ok", 32'(bus.p_addr_ok), 32'(win_p));
    chk("a_addr_ok", 32'(bus.a_addr_ok), 32'(win_a));
    chk("p_data_ok", 32'(bus.p_data_ok), 32'(done && m_owner == 0));
    chk("a_data_ok", 32'(bus.a_data_ok), 32'(done && m_owner == 1));
    chk("p_rdata",   bus.p_rdata, (done && m_owner == 0) ? rd : 32'd0);
    chk("a_rdata",   bus.a_rdata, (done && m_owner == 1) ? rd : 32'd0);
    chk("sram_en",   32'(bus.sram_en), 32'(win));
    chk("sram_we",   32'(bus.sram_we), (win && wr[w]) ? 32'(strb[w]) : 32'd0);
    chk("sram_addr", bus.sram_addr, win ? addr[w] : 32'd0);
    chk("sram_wdata", bus.sram_wdata, win ? wdata[w] : 32'd0);
    if (record_en) begin
      if (bus.a_addr_ok) gq.push_back(1);
      else if (bus.p_addr_ok) gq.push_back(0);
    end

    @(posedge clk);
    if (win) begin
      busy_end = cyc + RD_LAT;
      m_owner  = w;
      req[w]   = 1'b0;
      outst[w] = 1'b1;
      if (win_a || !req[1]) starve = 0;
      else starve = starve + 1;
    end
    cyc++;
    #1;
  endtask

  initial begin
    int exp_order[10];
    exp_order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    for (int k = 0; k < 2; k++) begin
      req[k] = 1'b0; wr[k] = 1'b0; strb[k] = 4'h0;
      addr[k] = 32'd0; wdata[k] = 32'd0; outst[k] = 1'b0; rate[k] = 0;
    end
    drive_bus();
    bus.sram_rdata = 32'd0;

    apply_reset(2);

    // both ports requesting continuously: aux wins every (STARVE_MAX+1)-th grant
    rate[0] = 100; rate[1] = 100;
    record_en = 1'b1;
    repeat (RD_LAT * 10) do_cycle();
    record_en = 1'b0;
    chk("order_len", 32'(gq.size()), 32'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < gq.size()) chk($sformatf("order_%0d", i), 32'(gq[i]), 32'(exp_order[i]));
    end

    rate[0] = 0; rate[1] = 0;
    repeat (RD_LAT + 2) do_cycle();

    // pipeline store with empty byte mask is still a full transaction
    req[0] = 1'b1; wr[0] = 1'b1; strb[0] = 4'h0;
    addr[0] = 32'h0000_0044; wdata[0] = 32'hCAFE_F00D;
    repeat (RD_LAT + 2) do_cycle();

    // pipeline load, then reset while it is in flight
    req[0] = 1'b1; wr[0] = 1'b0; strb[0] = 4'hF;
    addr[0] = 32'h0000_1000; wdata[0] = 32'h0;
    do_cycle();
    apply_reset(2);
    repeat (RD_LAT + 3) do_cycle();

    for (int blk = 0; blk < 15; blk++) begin
      rate[0] = $urandom_range(100);
      rate[1] = $urandom_range(100);
      repeat (200) do_cycle();
      if (blk == 7) apply_reset($urandom_range(3, 1));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/dsram_arbiter.md
Name: dsram_arbiter

Overview:
- Shares the single-port data SRAM between two requesters and sequences every access through a fixed read latency.
  - Pipeline port (p_): load/store traffic from the EX/MEM stages.
  - Auxiliary port (a_): debug/DMA traffic.
- Only one transaction is outstanding at a time.
- The pipeline port has priority. A starvation counter guarantees the auxiliary port forward progress.
- The MEM stage uses p_data_ok as its ready_go source for memory instructions.

Parameters:
- RD_LAT, 1, cycles from SRAM enable to valid sram_rdata; legal range 1..7.
- STARVE_MAX, 4, consecutive pipeline grants with a_req pending before aux is forced to win; legal range 1..15.

Ports:
- clk  input  1  clock.
- resetn  input  1  asynchronous, active-low reset.
- p_req  input  1  pipeline request valid.
- p_wr  input  1  1 = store, 0 = load.
- p_wstrb  input  4  store byte enables.
- p_addr  input  32  byte address.
- p_wdata  input  32  store data.
- p_addr_ok  output  1  pipeline request accepted this cycle.
- p_data_ok  output  1  pipeline transaction complete; p_rdata valid.
- p_rdata  output  32  load data.
- a_req, a_wr, a_wstrb, a_addr, a_wdata, a_addr_ok, a_data_ok, a_rdata: same directions, widths and meanings for the auxiliary port.
- sram_en  output  1  SRAM access enable.
- sram_we  output  4  SRAM byte write enables.
- sram_addr  output  32  SRAM address.
- sram_wdata  output  32  SRAM write data.
- sram_rdata  input  32  SRAM read data, valid RD_LAT cycles after sram_en.

Behaviour:
- Reset (resetn low, asynchronous):
  - state = IDLE, lat_cnt = 0, owner = none, starve_cnt = 0.
  - All *_ok, sram_en and sram_we are 0; sram_addr, sram_wdata, p_rdata and a_rdata are 0.
- States:
  - IDLE: no transaction in flight.
  - WAIT: transaction in flight; lat_cnt counts down from RD_LAT.
- can_accept = (state == IDLE) || (state == WAIT && lat_cnt == 1).
- Winner selection when can_accept:
  - Aux wins if a_req && (!p_req || starve_cnt == STARVE_MAX).
  - Otherwise pipeline wins if p_req.
  - Otherwise no grant.
- Grant cycle (cycle T):
  - Combinational: winner's addr_ok = 1; sram_en = 1; sram_addr/sram_wdata = winner's fields; sram_we = winner's wstrb if wr, else 4'b0000.
  - Registered: owner := winner, lat_cnt := RD_LAT, state := WAIT.
- Completion:
  - owner's data_ok = 1 exactly in cycle T+RD_LAT, i.e. the WAIT cycle with lat_cnt == 1. This holds for stores too.
  - That port's rdata = sram_rdata in the data_ok cycle and 0 otherwise; the other port's rdata = 0.
- Back-to-back:
  - A new grant may occur in the same cycle as data_ok, giving peak throughput of one transaction per RD_LAT cycles.
  - With RD_LAT = 1, every cycle may be both a completion and a grant.
  - If no new grant occurs in the lat_cnt == 1 cycle, state := IDLE.
- At most one addr_ok and at most one data_ok per cycle. Both may be high together (one completion, one grant).
- Starvation counter, updated on a grant cycle only:
  - Pipeline granted while a_req = 1 → starve_cnt + 1, saturating at STARVE_MAX.
  - Aux granted → 0.
  - Pipeline granted while a_req = 0 → 0.
  - No grant → hold.
- Requester contract:
  - req and all fields held stable until addr_ok.
  - req may drop or change after addr_ok.
  - A port does not raise a second req before its data_ok. The arbiter does not check this.
- Edge cases:
  - A store with wstrb = 0 is a full transaction: sram_en = 1, sram_we = 0, data_ok still returned.
  - Address alignment is not checked; sram_addr passes through unmodified.
  - Reset asserted mid-transaction drops the in-flight access; no data_ok follows after reset release.

Test Plan:
- RD_LAT = 1. Pipeline load addr 0x1000 at T (sram_rdata = 0xDEADBEEF at T+1) → p_addr_ok at T; sram_en = 1, sram_we = 0, sram_addr = 0x1000 at T; p_data_ok at T+1 with p_rdata = 0xDEADBEEF.
- RD_LAT = 3. Aux store addr 0x20, wstrb 4'b0011, wdata 0x12345678 at T → sram_we = 4'b0011 at T; a_data_ok only at T+3; a p_req raised at T+1 gets p_addr_ok at T+3, not before.
- RD_LAT = 1, STARVE_MAX = 4. p_req and a_req held continuously → grant order P, P, P, P, A, P, P, P, P, A; a_addr_ok every fifth grant.
- RD_LAT = 2. p_req and a_req rise simultaneously with starve_cnt = 0 → pipeline granted first, aux granted in the pipeline's data_ok cycle (T+2), a_data_ok at T+4.
- RD_LAT = 2. Pipeline load granted at T, resetn pulled low at T+1 and released at T+3 → all outputs 0 immediately at T+1; no p_data_ok at any later cycle; a new request at T+4 is accepted normally.
- Pipeline store with wstrb = 0 → sram_en = 1, sram_we = 0, p_data_ok returned after RD_LAT cycles.
